mod_n_down_counter: RTL and testbench

//  Cascaded, loadable mod-N down counter: the count-down counterpart of the mod-N up counter.

---
 rtl/mod_n_pkg.sv | 19 +
 rtl/mod_n_down_stage.sv | 37 +++
 rtl/mod_n_down_counter.sv | 55 +++++
 tb/tb_mod_n_down_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// Shared helpers for the cascaded mod-N down counter.
// Width and digit-limit functions used by the top and each stage.
package mod_n_pkg;

  localparam int unsigned DEF_N = 10;
  localparam int unsigned DEF_STAGES = 2;

  function automatic int unsigned width_of(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned digit_max(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mod_n_down_stage.sv
// One mod-N digit of the down counter with borrow in/out.
// Loads saturate to N-1 so the digit never leaves 0..N-1.
module mod_n_down_stage
  import mod_n_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = width_of(DEF_N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_digit,
  input  logic         borrow_in,
  output logic [W-1:0] q_digit,
  output logic         is_zero,
  output logic         borrow_out
);

  localparam logic [W-1:0] MAX = W'(digit_max(N));

  logic [W-1:0] sat_digit;

  assign sat_digit  = (load_digit > MAX) ? MAX : load_digit;
  assign is_zero    = (q_digit == '0);
  assign borrow_out = borrow_in & is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_digit <= '0;
    end else if (load) begin
      q_digit <= sat_digit;
    end else if (borrow_in) begin
      q_digit <= is_zero ? MAX : q_digit - 1'b1;
    end
  end

endmodule

// File: rtl/mod_n_down_counter.sv
// Cascaded loadable mod-N down counter with terminal count and
// a registered one-cycle underflow pulse on the all-zero wrap.
module mod_n_down_counter
  import mod_n_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            load,
  input  logic                            one_shot,
  input  logic [STAGES*width_of(N)-1:0]   load_val,
  output logic [STAGES*width_of(N)-1:0]   q,
  output logic                            tc,
  output logic                            underflow
);

  localparam int unsigned W = width_of(N);

  logic [STAGES:0]   borrow;
  logic [STAGES-1:0] zero;
  logic              all_zero;

  assign all_zero  = &zero;
  assign tc        = all_zero;
  // one-shot mode blocks the borrow so an all-zero count holds
  assign borrow[0] = en & ~(all_zero & one_shot);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mod_n_down_stage #(
      .N (N),
      .W (W)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_digit (load_val[k*W +: W]),
      .borrow_in  (borrow[k]),
      .q_digit    (q[k*W +: W]),
      .is_zero    (zero[k]),
      .borrow_out (borrow[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else begin
      underflow <= ~load & borrow[STAGES];
    end
  end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Scoreboard bench for the 2-digit decimal down counter.
// Expected values come from an integer 0..99 reference model.
module tb_mod_n_down_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       one_shot = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] q;
  logic       tc;
  logic       underflow;

  typedef struct {
    int q;
    int tc;
    int uf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cnt = 0;
  int   uf_m = 0;

  always #5 clk = ~clk;

  mod_n_down_counter #(.N(10), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .one_shot  (one_shot),
    .load_val  (load_val),
    .q         (q),
    .tc        (tc),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic int q_val();
    return int'(q[7:4]) * 10 + int'(q[3:0]);
  endfunction

  task automatic step(input string tag, input logic e, input logic l,
                      input logic os, input logic [7:0] lv);
    exp_t x;
    int   d0;
    int   d1;
    en = e;
    load = l;
    one_shot = os;
    load_val = lv;
    if (l) begin
      d0 = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
      d1 = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
      cnt = d1 * 10 + d0;
      uf_m = 0;
    end else if (e) begin
      if (cnt == 0) begin
        cnt = os ? 0 : 99;
        uf_m = os ? 0 : 1;
      end else begin
        cnt = cnt - 1;
        uf_m = 0;
      end
    end else begin
      uf_m = 0;
    end
    x.q = cnt;
    x.tc = (cnt == 0) ? 1 : 0;
    x.uf = uf_m;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".q"}, q_val(), x.q);
    chk({tag, ".tc"}, int'(tc), x.tc);
    chk({tag, ".uf"}, int'(underflow), x.uf);
  endtask

  initial begin
    #1;
    chk("rst.q", q_val(), 0);
    chk("rst.tc", int'(tc), 1);
    chk("rst.uf", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 8'h00);

    step("ld23", 0, 1, 0, 8'h23);
    for (int i = 0; i < 4; i++) step("dn", 1, 0, 0, 8'h00);

    step("ld00", 0, 1, 0, 8'h00);
    step("wrap", 1, 0, 0, 8'h00);
    step("post", 1, 0, 0, 8'h00);

    step("ld01", 0, 1, 1, 8'h01);
    for (int i = 0; i < 3; i++) step("os", 1, 0, 1, 8'h00);

    step("sat", 1, 1, 0, 8'hC4);
    step("hold", 0, 0, 0, 8'h00);

    step("ld57", 0, 1, 0, 8'h57);
    step("c56", 1, 0, 0, 8'h00);
    step("c55", 1, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    cnt = 0;
    uf_m = 0;
    chk("arst.q", q_val(), 0);
    chk("arst.tc", int'(tc), 1);
    chk("arst.uf", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rwrap", 1, 0, 0, 8'h00);
    step("r98", 1, 0, 0, 8'h00);

    for (int i = 0; i < 20; i++)
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    chk("sb.empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
